// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the counter values used on reset and on allocation.
package branch_predictor_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    localparam logic [1:0] BP_CTR_RESET = BP_WNT;
    localparam logic [1:0] BP_CTR_ALLOC = BP_WT;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-state logic for a 2-bit saturating direction counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (taken) begin
            if (ctr != BP_ST) ctr_nxt = ctr + 2'd1;
        end else if (ctr != BP_SNT) begin
            ctr_nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; combinational lookup, one
// write port trained from EX. Define BP_PERF_COUNTERS_EN to add hit/mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    input  logic        lookup_valid,
    output logic        branch_estimation,
    output logic [31:0] branch_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_mispredict,
    input  logic        bp_flush
`ifdef BP_PERF_COUNTERS_EN
    ,
    output logic [31:0] lookup_hit_count,
    output logic [31:0] mispredict_count
`endif
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [1:0]       ctr_nxt;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[31:IDX_W+2];

    // Reads see registered state only, so a same-cycle update is invisible here.
    assign lk_hit            = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign branch_estimation = lk_hit && ctr_q[lk_idx][1];
    assign branch_target     = lk_hit ? tgt_q[lk_idx] : 32'h0;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    bp_sat_counter u_sat (
        .ctr     (ctr_q[up_idx]),
        .taken   (update_taken),
        .ctr_nxt (ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= BP_CTR_RESET;
            end
        end else if (bp_flush) begin
            valid_q <= '0;
        end else if (update_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_nxt;
                if (update_taken) tgt_q[up_idx] <= update_target;
            end else if (update_taken) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= update_target;
                ctr_q[up_idx]   <= BP_CTR_ALLOC;
            end
        end
    end

    logic unused_bits;
`ifdef BP_PERF_COUNTERS_EN
    assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    // Flush does not clear these; only reset does.
    always_ff @(posedge clk) begin
        if (reset) begin
            lookup_hit_count <= '0;
            mispredict_count <= '0;
        end else begin
            if (lookup_valid && lk_hit)            lookup_hit_count <= lookup_hit_count + 32'd1;
            if (update_valid && update_mispredict) mispredict_count <= mispredict_count + 32'd1;
        end
    end
`else
    assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0], lookup_valid, update_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor; perf-counter checks are built when
// BP_PERF_COUNTERS_EN is defined.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] lookup_pc = '0;
    logic        lookup_valid = 1'b0;
    logic        branch_estimation;
    logic [31:0] branch_target;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_mispredict = 1'b0;
    logic        bp_flush = 1'b0;
`ifdef BP_PERF_COUNTERS_EN
    logic [31:0] lookup_hit_count;
    logic [31:0] mispredict_count;
`endif

    typedef struct {
        string       name;
        logic        est;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .lookup_pc         (lookup_pc),
        .lookup_valid      (lookup_valid),
        .branch_estimation (branch_estimation),
        .branch_target     (branch_target),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .bp_flush          (bp_flush)
`ifdef BP_PERF_COUNTERS_EN
        ,
        .lookup_hit_count  (lookup_hit_count),
        .mispredict_count  (mispredict_count)
`endif
    );

    // One update, applied on the next rising edge.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic misp);
        @(negedge clk);
        update_valid = 1'b1; update_pc = pc; update_taken = tk;
        update_target = tgt; update_mispredict = misp;
        @(negedge clk);
        update_valid = 1'b0; update_mispredict = 1'b0;
    endtask

    // Drives a lookup and records what the outputs must show for it.
    task automatic drive_lookup(input string name, input logic [31:0] pc, input logic est, input logic [31:0] tgt);
        @(negedge clk);
        lookup_pc = pc;
        sb.push_back('{name: name, est: est, tgt: tgt});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive_lookup("reset_0x100", 32'h100, 1'b0, 32'h0);
        #1; e = sb.pop_front(); total++;
        if (branch_estimation !== e.est || branch_target !== e.tgt) begin
            bad++; $display("FAIL %s: got est=%0b tgt=%h want est=%0b tgt=%h", e.name, branch_estimation, branch_target, e.est, e.tgt);
        end
    endtask

    task automatic test_allocate();
        string       nm  [3] = '{"alloc_hit", "alloc_pcbits_ignored", "alloc_other_idx_miss"};
        logic [31:0] pcs [3] = '{32'h100, 32'h103, 32'h104};
        logic        ests[3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] tgts[3] = '{32'h200, 32'h200, 32'h0};
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_lookup(nm[i], pcs[i], ests[i], tgts[i]);
            #1; e = sb.pop_front(); total++;
            if (branch_estimation !== e.est || branch_target !== e.tgt) begin
                bad++; $display("FAIL %s: got est=%0b tgt=%h want est=%0b tgt=%h", e.name, branch_estimation, branch_target, e.est, e.tgt);
            end
        end
    endtask

    // Starts at WT; walks down past SNT and up past ST to check both saturation ends.
    task automatic test_saturate();
        string       nm  [7] = '{"ctr_wnt", "ctr_snt", "ctr_snt_sat", "ctr_wnt_up", "ctr_wt_up", "ctr_st", "ctr_st_sat"};
        logic        tks [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] utg [7] = '{32'h999, 32'h999, 32'h999, 32'h250, 32'h260, 32'h270, 32'h280};
        logic        ests[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] tgts[7] = '{32'h200, 32'h200, 32'h200, 32'h250, 32'h260, 32'h270, 32'h280};
        for (int i = 0; i < 7; i++) begin
            upd(32'h100, tks[i], utg[i], 1'b0);
            drive_lookup(nm[i], 32'h100, ests[i], tgts[i]);
            #1; e = sb.pop_front(); total++;
            if (branch_estimation !== e.est || branch_target !== e.tgt) begin
                bad++; $display("FAIL %s: got est=%0b tgt=%h want est=%0b tgt=%h", e.name, branch_estimation, branch_target, e.est, e.tgt);
            end
        end
        upd(32'h100, 1'b0, 32'h999, 1'b0);
        drive_lookup("ctr_st_down_wt", 32'h100, 1'b1, 32'h280);
        #1; e = sb.pop_front(); total++;
        if (branch_estimation !== e.est || branch_target !== e.tgt) begin
            bad++; $display("FAIL %s: got est=%0b tgt=%h want est=%0b tgt=%h", e.name, branch_estimation, branch_target, e.est, e.tgt);
        end
    endtask

    // 0x100 and 0x140 share index 0 with ENTRIES=16.
    task automatic test_alias();
        string       nm  [3] = '{"alias_old_miss", "alias_new_hit", "alias_nt_miss_nochange"};
        logic [31:0] pcs [3] = '{32'h100, 32'h140, 32'h140};
        logic        ests[3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] tgts[3] = '{32'h0, 32'h400, 32'h400};
        upd(32'h140, 1'b1, 32'h400, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) upd(32'h100, 1'b0, 32'h777, 1'b0);
            drive_lookup(nm[i], pcs[i], ests[i], tgts[i]);
            #1; e = sb.pop_front(); total++;
            if (branch_estimation !== e.est || branch_target !== e.tgt) begin
                bad++; $display("FAIL %s: got est=%0b tgt=%h want est=%0b tgt=%h", e.name, branch_estimation, branch_target, e.est, e.tgt);
            end
        end
    endtask

    task automatic test_back_to_back();
        string       nm  [3] = '{"flush_0x140", "flush_0x108", "flush_drop_0x10c"};
        logic [31:0] pcs [3] = '{32'h140, 32'h108, 32'h10C};
        // Lookup during a same-index update sees the old target.
        drive_lookup("rdw_old", 32'h140, 1'b1, 32'h400);
        update_valid = 1'b1; update_pc = 32'h140; update_taken = 1'b1; update_target = 32'h500;
        #1; e = sb.pop_front(); total++;
        if (branch_estimation !== e.est || branch_target !== e.tgt) begin
            bad++; $display("FAIL %s: got est=%0b tgt=%h want est=%0b tgt=%h", e.name, branch_estimation, branch_target, e.est, e.tgt);
        end
        @(negedge clk); update_valid = 1'b0;
        drive_lookup("rdw_new", 32'h140, 1'b1, 32'h500);
        #1; e = sb.pop_front(); total++;
        if (branch_estimation !== e.est || branch_target !== e.tgt) begin
            bad++; $display("FAIL %s: got est=%0b tgt=%h want est=%0b tgt=%h", e.name, branch_estimation, branch_target, e.est, e.tgt);
        end
        // Flush with a concurrent allocate: everything misses, allocate lost.
        upd(32'h108, 1'b1, 32'h800, 1'b0);
        @(negedge clk);
        bp_flush = 1'b1; update_valid = 1'b1; update_pc = 32'h10C; update_taken = 1'b1; update_target = 32'h900;
        @(negedge clk);
        bp_flush = 1'b0; update_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_lookup(nm[i], pcs[i], 1'b0, 32'h0);
            #1; e = sb.pop_front(); total++;
            if (branch_estimation !== e.est || branch_target !== e.tgt) begin
                bad++; $display("FAIL %s: got est=%0b tgt=%h want est=%0b tgt=%h", e.name, branch_estimation, branch_target, e.est, e.tgt);
            end
        end
    endtask

    task automatic test_reset_midstream();
        upd(32'h110, 1'b1, 32'hA00, 1'b0);
        drive_lookup("pre_reset_hit", 32'h110, 1'b1, 32'hA00);
        #1; e = sb.pop_front(); total++;
        if (branch_estimation !== e.est || branch_target !== e.tgt) begin
            bad++; $display("FAIL %s: got est=%0b tgt=%h want est=%0b tgt=%h", e.name, branch_estimation, branch_target, e.est, e.tgt);
        end
        @(negedge clk);
        reset = 1'b1; update_valid = 1'b1; update_pc = 32'h114; update_taken = 1'b1; update_target = 32'hB00;
        @(negedge clk);
        reset = 1'b0; update_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_lookup(i == 0 ? "reset_clears_0x110" : "reset_drops_0x114", i == 0 ? 32'h110 : 32'h114, 1'b0, 32'h0);
            #1; e = sb.pop_front(); total++;
            if (branch_estimation !== e.est || branch_target !== e.tgt) begin
                bad++; $display("FAIL %s: got est=%0b tgt=%h want est=%0b tgt=%h", e.name, branch_estimation, branch_target, e.est, e.tgt);
            end
        end
    endtask

`ifdef BP_PERF_COUNTERS_EN
    task automatic test_perf();
        logic [31:0] exp_hits, exp_misp;
        exp_hits = 0; exp_misp = 0;
        #1; total++;
        if (lookup_hit_count !== exp_hits || mispredict_count !== exp_misp) begin
            bad++; $display("FAIL perf_after_reset: got hits=%0d misp=%0d want 0 0", lookup_hit_count, mispredict_count);
        end
        upd(32'h100, 1'b1, 32'h200, 1'b1); exp_misp++;
        upd(32'h100, 1'b1, 32'h200, 1'b1); exp_misp++;
        @(negedge clk); update_mispredict = 1'b1;   // without update_valid: must not count
        @(negedge clk); update_mispredict = 1'b0;
        lookup_pc = 32'h100; lookup_valid = 1'b1;
        repeat (3) begin @(negedge clk); exp_hits++; end
        lookup_valid = 1'b0;
        lookup_pc = 32'h104; lookup_valid = 1'b1;   // misses are not counted
        @(negedge clk); lookup_valid = 1'b0;
        #1; total++;
        if (lookup_hit_count !== exp_hits || mispredict_count !== exp_misp) begin
            bad++; $display("FAIL perf_counts: got hits=%0d misp=%0d want %0d %0d", lookup_hit_count, mispredict_count, exp_hits, exp_misp);
        end
        @(negedge clk); bp_flush = 1'b1; @(negedge clk); bp_flush = 1'b0;
        #1; total++;
        if (lookup_hit_count !== exp_hits || mispredict_count !== exp_misp) begin
            bad++; $display("FAIL perf_flush_keeps: got hits=%0d misp=%0d want %0d %0d", lookup_hit_count, mispredict_count, exp_hits, exp_misp);
        end
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        #1; total++;
        if (lookup_hit_count !== 32'd0 || mispredict_count !== 32'd0) begin
            bad++; $display("FAIL perf_reset_clears: got hits=%0d misp=%0d want 0 0", lookup_hit_count, mispredict_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_allocate();
        test_saturate();
        test_alias();
        test_back_to_back();
        test_reset_midstream();
`ifdef BP_PERF_COUNTERS_EN
        test_perf();
`endif
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
